serial_alu_ctrl: RTL and testbench

//  Bit-serial ALU sequencer. Accepts one WIDTH-bit operation, then drives a single 1-bit ALU slice
//  (alu1Bit) once per cycle, LSB first, holding the ripple carry in a flop between cycles.

---
 rtl/serial_alu_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_serial_alu_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_ctrl.sv
// ---------------------------------------------------------------------------
// serial_alu_ctrl
//
// Bit-serial ALU sequencer. One WIDTH-bit operation is accepted through a
// valid/ready handshake. A single 1-bit ALU slice then processes it LSB
// first, one bit per clock. The ripple carry is held in a flop between
// cycles. The assembled result and flags are presented through a second
// valid/ready handshake.
//
// Parameters
//   WIDTH      operand/result width in bits (>= 2)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation request
//   in_ready   block can accept a request (high only in IDLE)
//   alu_op     4-bit opcode, captured on accept
//   op_a       operand A, captured on accept
//   op_b       operand B, captured on accept
//   out_valid  result available (high only in DONE)
//   out_ready  consumer takes the result
//   abort      (only with SERIAL_ALU_ABORT_EN) abandons the operation in RUN
//   result     assembled result
//   carry_out  carry out of the MSB slice (ADD/SUB), else 0
//   overflow   signed overflow (ADD/SUB), else 0
//   zero       result == 0
//   op_err     captured opcode is unsupported
//
// Configuration
//   SERIAL_ALU_ABORT_EN  adds the abort input. When it is undefined, the
//                        port is absent and RUN always lasts WIDTH edges.
// ---------------------------------------------------------------------------
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SERIAL_ALU_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             op_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry_q;
  logic [CW-1:0]    bit_cnt;

  logic             slice_b;
  logic             slice_sum;
  logic             slice_cout;
  logic             op_ok;
  logic             is_arith;
  logic [WIDTH-1:0] res_next;
  logic             abort_hit;

  // Without the abort option, the abort condition is tied off.
  // This keeps a single RUN code path for both builds.
`ifdef SERIAL_ALU_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // The 1-bit ALU slice. It always looks at the LSBs of the captured operand
  // shift registers and at the carry flop. SUB is an add with B inverted;
  // its carry flop was preloaded with 1 on accept.
  always_comb begin
    slice_b    = (op_q == OP_SUB) ? ~b_sh[0] : b_sh[0];
    slice_sum  = 1'b0;
    slice_cout = 1'b0;
    op_ok      = 1'b1;
    case (op_q)
      OP_AND:  slice_sum = a_sh[0] & b_sh[0];
      OP_OR:   slice_sum = a_sh[0] | b_sh[0];
      OP_ADD,
      OP_SUB: begin
        slice_sum  = a_sh[0] ^ slice_b ^ carry_q;
        slice_cout = (a_sh[0] & slice_b) | (a_sh[0] & carry_q) | (slice_b & carry_q);
      end
      OP_NOR:  slice_sum = ~a_sh[0] & ~b_sh[0];
      OP_NAND: slice_sum = ~a_sh[0] | ~b_sh[0];
      default: op_ok = 1'b0;
    endcase
  end

  // The new slice bit enters at the MSB. After WIDTH shifts, the first bit
  // produced has reached bit 0.
  assign res_next = {slice_sum, res_sh[WIDTH-1:1]};
  assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

  // Sequencer FSM with registered handshake and result outputs.
  // On the last RUN edge, carry_q still holds the carry into the MSB slice.
  // XOR-ing it with the slice carry-out gives signed overflow.
  // Result outputs are written only on DONE entry. They therefore hold
  // their values through IDLE, aborts and backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      op_err    <= 1'b0;
      op_q      <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      carry_q   <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= RUN;
            in_ready <= 1'b0;
            op_q     <= alu_op;
            a_sh     <= op_a;
            b_sh     <= op_b;
            res_sh   <= '0;
            carry_q  <= (alu_op == OP_SUB);
            bit_cnt  <= '0;
          end
        end
        RUN: begin
          if (abort_hit) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end else begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            res_sh  <= res_next;
            carry_q <= slice_cout;
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == LAST_BIT) begin
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= res_next;
              carry_out <= is_arith & slice_cout;
              overflow  <= is_arith & (carry_q ^ slice_cout);
              zero      <= (res_next == '0);
              op_err    <= ~op_ok;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_alu_ctrl
//
// Self-checking bench for serial_alu_ctrl with WIDTH=8.
// Expected results come from a word-level reference model. Each model
// result is pushed to a queue when its operation is issued. It is popped
// and compared when the DUT raises out_valid.
// ---------------------------------------------------------------------------
module tb_serial_alu_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         v;
    logic         z;
    logic         e;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_op;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
`ifdef SERIAL_ALU_ABORT_EN
  logic         abort;
`endif
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;
  logic         zero;
  logic         op_err;

  int   tests_run;
  int   tests_failed;
  exp_t sb[$];

  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SERIAL_ALU_ABORT_EN
    .abort     (abort),
`endif
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .op_err    (op_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: whole-word arithmetic, independent of the serial slice.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t       e;
    logic [W:0] s;
    e = '0;
    s = '0;
    case (op)
      4'b0000: e.r = a & b;
      4'b0001: e.r = a | b;
      4'b0010: begin
        s   = {1'b0, a} + {1'b0, b};
        e.r = s[W-1:0];
        e.c = s[W];
        e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      4'b0110: begin
        s   = {1'b0, a} + {1'b0, ~b} + 9'd1;
        e.r = s[W-1:0];
        e.c = s[W];
        e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
      end
      4'b1100: e.r = ~(a | b);
      4'b1101: e.r = ~(a & b);
      default: e.e = 1'b1;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Drives one request in IDLE. Returns one time unit after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit push);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1;
    alu_op   = op;
    op_a     = a;
    op_b     = b;
    if (push) sb.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a     = W'($urandom);
    op_b     = W'($urandom);
    alu_op   = 4'($urandom);
  endtask

  // Counts edges from the accept edge until out_valid, bounded at 40.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({in_ready, out_valid} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL reset_handshake: in_ready,out_valid=%b required 10", {in_ready, out_valid});
    end
    tests_run++;
    if ({result, carry_out, overflow, zero, op_err} !== 12'h000) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %h required 000", {result, carry_out, overflow, zero, op_err});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_overflow();
    int   lat;
    exp_t e;
    issue(4'b0010, 8'h7F, 8'h01, 1'b1);
    wait_done(lat);
    tests_run++;
    if (lat !== W) begin
      tests_failed++;
      $display("[TB] FAIL add_latency: got %0d edges required %0d", lat, W);
    end
    e = sb.pop_front();
    tests_run++;
    if ({result, carry_out, overflow, zero, op_err} !== 12'h804 || e !== 12'h804) begin
      tests_failed++;
      $display("[TB] FAIL add_7f_01: got %h required %h", {result, carry_out, overflow, zero, op_err}, e);
    end
    take_result();
  endtask

  task automatic test_ops();
    logic [3:0]   ops[8] = '{4'b0110, 4'b0110, 4'b1100, 4'b1101, 4'b0011, 4'b0000, 4'b0001, 4'b0010};
    logic [W-1:0] as[8]  = '{8'h05, 8'h00, 8'hF0, 8'hFF, 8'h5A, 8'hCC, 8'hA0, 8'hFF};
    logic [W-1:0] bs[8]  = '{8'h05, 8'h01, 8'h0F, 8'h0F, 8'hA5, 8'hAA, 8'h05, 8'h01};
    int   lat;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i], 1'b1);
      wait_done(lat);
      e = sb.pop_front();
      tests_run++;
      if ({result, carry_out, overflow, zero, op_err} !== e) begin
        tests_failed++;
        $display("[TB] FAIL op%0d_%b: got %h required %h", i, ops[i],
                 {result, carry_out, overflow, zero, op_err}, e);
      end
      tests_run++;
      if ({out_valid, in_ready} !== 2'b10) begin
        tests_failed++;
        $display("[TB] FAIL op%0d_handshake: out_valid,in_ready=%b required 10", i, {out_valid, in_ready});
      end
      take_result();
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    exp_t e;
    issue(4'b0010, 8'h3C, 8'h4B, 1'b1);
    wait_done(lat);
    e = sb.pop_front();
    @(negedge clk);
    in_valid = 1'b1;
    alu_op   = 4'b0000;
    op_a     = 8'hFF;
    op_b     = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if ({out_valid, in_ready, result, carry_out, overflow, zero, op_err} !== {2'b10, e}) begin
        tests_failed++;
        $display("[TB] FAIL backpressure_cycle%0d: got %h required %h", i,
                 {out_valid, in_ready, result, carry_out, overflow, zero, op_err}, {2'b10, e});
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL release_no_accept: out_valid,in_ready=%b required 01", {out_valid, in_ready});
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({in_ready, result, carry_out, overflow, zero, op_err} !== {1'b1, e}) begin
      tests_failed++;
      $display("[TB] FAIL idle_hold: got %h required %h",
               {in_ready, result, carry_out, overflow, zero, op_err}, {1'b1, e});
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    issue(4'b0010, 8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({in_ready, out_valid, result, carry_out, overflow, zero, op_err} !== 14'h2000) begin
      tests_failed++;
      $display("[TB] FAIL mid_run_reset: got %h required 2000",
               {in_ready, out_valid, result, carry_out, overflow, zero, op_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen !== 0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL mid_run_discard: out_valid cycles=%0d in_ready=%b required 0 and 1", seen, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pool[7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1101, 4'b1010};
    logic [3:0] op;
    int   lat;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      op = pool[$urandom_range(0, 6)];
      issue(op, W'($urandom), W'($urandom), 1'b1);
      wait_done(lat);
      tests_run++;
      if (lat !== W) begin
        tests_failed++;
        $display("[TB] FAIL b2b%0d_latency: got %0d required %0d", i, lat, W);
      end
      e = sb.pop_front();
      tests_run++;
      if ({result, carry_out, overflow, zero, op_err} !== e) begin
        tests_failed++;
        $display("[TB] FAIL b2b%0d_op%b: got %h required %h", i, op,
                 {result, carry_out, overflow, zero, op_err}, e);
      end
      take_result();
    end
  endtask

`ifdef SERIAL_ALU_ABORT_EN
  task automatic test_abort();
    int   lat;
    int   seen;
    exp_t e;
    issue(4'b0001, 8'h81, 8'h18, 1'b1);
    wait_done(lat);
    e = sb.pop_front();
    take_result();
    issue(4'b0010, 8'h11, 8'h22, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    tests_run++;
    if ({in_ready, out_valid, result, carry_out, overflow, zero, op_err} !== {2'b10, e}) begin
      tests_failed++;
      $display("[TB] FAIL abort_idle: got %h required %h",
               {in_ready, out_valid, result, carry_out, overflow, zero, op_err}, {2'b10, e});
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("[TB] FAIL abort_no_valid: out_valid cycles=%0d required 0", seen);
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    alu_op       = '0;
    op_a         = '0;
    op_b         = '0;
`ifdef SERIAL_ALU_ABORT_EN
    abort        = 1'b0;
`endif
    test_reset();
    test_add_overflow();
    test_ops();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
`ifdef SERIAL_ALU_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
